// File: rtl/output_stream_scheduler.sv
// output_stream_scheduler_fifo: generic synchronous FIFO used for the descriptor queue.
// Latency: a pushed entry is visible at head_dat one cycle after the push edge.
// Backpressure: push_rdy low while full; pop while empty is ignored.
//
// Ports:
//   clk / rst_n                clock, synchronous active-low reset
//   push_vld/push_rdy/push_dat write side (valid/ready)
//   pop/head_dat/empty         read side, head is always presented
module output_stream_scheduler_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Separate occupancy count distinguishes full from empty when pointers meet.
  assign push_rdy = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// output_stream_scheduler: queues output-job descriptors and runs the stream-out engine one job at a time.
// Latency: descriptor accepted at edge N -> start_output high after edge N+2; job_done one cycle after tlast/timeout.
// Backpressure: desc_ready drops while the descriptor queue is full; the snooped stream is never stalled.
//
// Ports:
//   m_axis_aclk / m_axis_aresetn        clock, synchronous active-low reset
//   desc_valid/desc_ready/desc_*        descriptor push from the layer controller
//   start_output, out_size, groups,     drive to the stream-out engine for the current job
//   out_base
//   mon_tvalid/mon_tready/mon_tlast     snooped master AXI-Stream handshake
//   job_done, job_status                completion pulse; status 0 ok, 1 timeout, 2 bad descriptor
//   busy, err_sticky, jobs_done_count   activity flag, sticky error, wrapping completion count
module output_stream_scheduler #(
  parameter int MAX_ADDR_WIDTH = 13,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_aresetn,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [MAX_ADDR_WIDTH-1:0] desc_base,
  input  logic [MAX_ADDR_WIDTH-1:0] desc_size,
  input  logic [3:0]                desc_groups,
  output logic                      start_output,
  output logic [MAX_ADDR_WIDTH-1:0] out_size,
  output logic [3:0]                groups,
  output logic [MAX_ADDR_WIDTH-1:0] out_base,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  input  logic                      mon_tlast,
  output logic                      job_done,
  output logic [1:0]                job_status,
  output logic                      busy,
  output logic                      err_sticky,
  output logic [CNT_WIDTH-1:0]      jobs_done_count
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] base;
    logic [MAX_ADDR_WIDTH-1:0] size;
    logic [3:0]                groups;
  } desc_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  desc_t         desc_in_dat;
  desc_t         head_dat;
  logic          fifo_rdy;
  logic          fifo_empty;
  logic          ready_en;
  logic          pop;
  logic          load_en;
  logic          beat;
  logic          done_nxt;
  logic [1:0]    status_nxt;
  logic [TW-1:0] stall_cnt;
  logic [TW-1:0] stall_nxt;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_nxt;

  assign desc_in_dat = '{base: desc_base, size: desc_size, groups: desc_groups};

  // ready_en keeps desc_ready low while reset is held; it rises on the first edge after release.
  assign desc_ready = ready_en & fifo_rdy;

  output_stream_scheduler_fifo #(
    .WIDTH ($bits(desc_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_desc_fifo (
    .clk      (m_axis_aclk),
    .rst_n    (m_axis_aresetn),
    .push_vld (desc_valid & desc_ready),
    .push_rdy (fifo_rdy),
    .push_dat (desc_in_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty)
  );

  // The monitored stream only matters while a job is running.
  assign beat         = (state == RUN) & mon_tvalid & mon_tready;
  assign start_output = (state == RUN);
  assign busy         = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_en    = 1'b0;
    done_nxt   = 1'b0;
    status_nxt = 2'd0;
    stall_nxt  = stall_cnt;
    gap_nxt    = gap_cnt;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = LOAD;
      end
      LOAD: begin
        pop       = 1'b1;
        load_en   = 1'b1;
        stall_nxt = '0;
        gap_nxt   = '0;
        // A zero-length or zero-group job would never produce tlast; reject it here.
        if (head_dat.size == '0 || head_dat.groups == '0) begin
          done_nxt   = 1'b1;
          status_nxt = 2'd2;
          state_nxt  = GAP;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // tlast is tested first so a final beat on the expiry cycle still completes cleanly.
        if (beat && mon_tlast) begin
          done_nxt   = 1'b1;
          status_nxt = 2'd0;
          state_nxt  = GAP;
          gap_nxt    = '0;
        end else if (!beat && stall_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          done_nxt   = 1'b1;
          status_nxt = 2'd1;
          state_nxt  = GAP;
          gap_nxt    = '0;
        end else if (beat) begin
          stall_nxt = '0;
        end else begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end
      GAP: begin
        // Hold start_output low long enough for the engine to clear its done flag.
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
        else                                gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      ready_en        <= 1'b0;
      stall_cnt       <= '0;
      gap_cnt         <= '0;
      out_base        <= '0;
      out_size        <= '0;
      groups          <= '0;
      job_done        <= 1'b0;
      job_status      <= 2'd0;
      err_sticky      <= 1'b0;
      jobs_done_count <= '0;
    end else begin
      ready_en   <= 1'b1;
      stall_cnt  <= stall_nxt;
      gap_cnt    <= gap_nxt;
      job_done   <= done_nxt;
      job_status <= status_nxt;
      if (load_en) begin
        out_base <= head_dat.base;
        out_size <= head_dat.size;
        groups   <= head_dat.groups;
      end
      // Counter and sticky flag move on the same edge that presents the pulse.
      if (done_nxt)                       jobs_done_count <= jobs_done_count + 1'b1;
      if (done_nxt && status_nxt != 2'd0) err_sticky      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_output_stream_scheduler.sv
module tb_output_stream_scheduler;
  localparam int AW = 13;

  logic          m_axis_aclk = 1'b0;
  logic          m_axis_aresetn;
  logic          desc_valid;
  logic          desc_ready;
  logic [AW-1:0] desc_base;
  logic [AW-1:0] desc_size;
  logic [3:0]    desc_groups;
  logic          start_output;
  logic [AW-1:0] out_size;
  logic [3:0]    groups;
  logic [AW-1:0] out_base;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic          job_done;
  logic [1:0]    job_status;
  logic          busy;
  logic          err_sticky;
  logic [15:0]   jobs_done_count;

  always #5 m_axis_aclk = ~m_axis_aclk;

  output_stream_scheduler #(
    .MAX_ADDR_WIDTH (AW),
    .FIFO_DEPTH     (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16),
    .CNT_WIDTH      (16)
  ) dut (
    .m_axis_aclk     (m_axis_aclk),
    .m_axis_aresetn  (m_axis_aresetn),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_base       (desc_base),
    .desc_size       (desc_size),
    .desc_groups     (desc_groups),
    .start_output    (start_output),
    .out_size        (out_size),
    .groups          (groups),
    .out_base        (out_base),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .job_done        (job_done),
    .job_status      (job_status),
    .busy            (busy),
    .err_sticky      (err_sticky),
    .jobs_done_count (jobs_done_count)
  );

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  typedef struct {
    int dv, base, size, grp, tv, tr, tl;
    int rdy, so, jd, js, busy, cnt, ob, os, og;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge m_axis_aclk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int b, input int s, input int g);
    check("push_rdy", int'(desc_ready), 1);
    desc_valid  = 1'b1;
    desc_base   = AW'(b);
    desc_size   = AW'(s);
    desc_groups = 4'(g);
    tick();
    desc_valid  = 1'b0;
  endtask

  task automatic beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
    tick();
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (!start_output && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", int'(start_output), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_seen", int'(busy), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish by 50000");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    int bad_pulses;
    int qb[5];

    //           dv  base   sz grp tv tr tl | rdy so jd js busy cnt  ob    os  og
    tbl[0]  = '{1, 'h100, 12, 2,  0, 0, 0,  1,  0, 0, 0, 0,   0,  0,    0,  0};
    tbl[1]  = '{0, 0,     0,  0,  1, 1, 1,  1,  0, 0, 0, 1,   0,  0,    0,  0};
    tbl[2]  = '{0, 0,     0,  0,  1, 1, 1,  1,  0, 0, 0, 1,   0,  0,    0,  0};
    tbl[3]  = '{0, 0,     0,  0,  1, 1, 0,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[4]  = '{0, 0,     0,  0,  1, 1, 0,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[5]  = '{0, 0,     0,  0,  1, 0, 1,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[6]  = '{0, 0,     0,  0,  1, 1, 0,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[7]  = '{0, 0,     0,  0,  1, 1, 0,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[8]  = '{0, 0,     0,  0,  1, 1, 0,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[9]  = '{0, 0,     0,  0,  1, 1, 1,  1,  1, 0, 0, 1,   0,  'h100, 12, 2};
    tbl[10] = '{0, 0,     0,  0,  0, 0, 0,  1,  0, 1, 0, 1,   1,  'h100, 12, 2};
    tbl[11] = '{0, 0,     0,  0,  0, 0, 0,  1,  0, 0, 0, 1,   1,  'h100, 12, 2};
    tbl[12] = '{0, 0,     0,  0,  0, 0, 0,  1,  0, 0, 0, 0,   1,  'h100, 12, 2};
    tbl[13] = '{0, 0,     0,  0,  0, 0, 0,  1,  0, 0, 0, 0,   1,  'h100, 12, 2};

    m_axis_aresetn = 1'b0;
    desc_valid     = 1'b0;
    desc_base      = '0;
    desc_size      = '0;
    desc_groups    = '0;
    mon_tvalid     = 1'b0;
    mon_tready     = 1'b0;
    mon_tlast      = 1'b0;
    tick();
    tick();
    check("rst_start", int'(start_output), 0);
    check("rst_done", int'(job_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(jobs_done_count), 0);
    check("rst_err", int'(err_sticky), 0);
    m_axis_aresetn = 1'b1;
    tick();
    check("rst_rdy_after", int'(desc_ready), 1);

    // Single job, cycle by cycle: 6 beats, one non-handshake tlast, monitor noise before RUN.
    for (int i = 0; i < 14; i++) begin
      desc_valid  = tbl[i].dv[0];
      desc_base   = AW'(tbl[i].base);
      desc_size   = AW'(tbl[i].size);
      desc_groups = 4'(tbl[i].grp);
      mon_tvalid  = tbl[i].tv[0];
      mon_tready  = tbl[i].tr[0];
      mon_tlast   = tbl[i].tl[0];
      check($sformatf("tbl%0d_rdy", i), int'(desc_ready), tbl[i].rdy);
      check($sformatf("tbl%0d_start", i), int'(start_output), tbl[i].so);
      check($sformatf("tbl%0d_done", i), int'(job_done), tbl[i].jd);
      check($sformatf("tbl%0d_status", i), int'(job_status), tbl[i].js);
      check($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
      check($sformatf("tbl%0d_cnt", i), int'(jobs_done_count), tbl[i].cnt);
      check($sformatf("tbl%0d_base", i), int'(out_base), tbl[i].ob);
      check($sformatf("tbl%0d_size", i), int'(out_size), tbl[i].os);
      check($sformatf("tbl%0d_groups", i), int'(groups), tbl[i].og);
      tick();
    end
    desc_valid = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    exp_cnt = 1;
    check("single_err", int'(err_sticky), 0);

    // Queue full: job A stalls in RUN while B..E fill the queue and F waits for the first pop.
    push('h10, 4, 1);
    wait_start(10, n);
    check("qA_latency", n, 2);
    check("qA_base", int'(out_base), 'h10);
    push('h20, 4, 1);
    push('h30, 4, 1);
    push('h40, 4, 1);
    push('h50, 4, 1);
    check("q_full_rdy", int'(desc_ready), 0);
    check("q_full_busy", int'(busy), 1);
    desc_valid  = 1'b1;
    desc_base   = AW'('h60);
    desc_size   = AW'(4);
    desc_groups = 4'(1);
    tick();
    check("q_hold_rdy", int'(desc_ready), 0);
    beat(1'b1);
    check("qA_done", int'(job_done), 1);
    check("qA_status", int'(job_status), 0);
    exp_cnt++;
    n = 0;
    while (!desc_ready && n < 20) begin
      tick();
      n++;
    end
    check("q_pop_wait", n, 4);
    check("qB_start", int'(start_output), 1);
    tick();
    desc_valid = 1'b0;
    qb = '{'h20, 'h30, 'h40, 'h50, 'h60};
    for (int k = 0; k < 5; k++) begin
      wait_start(10, n);
      if (k > 0) check($sformatf("q%0d_gap", k), n, 4);
      check($sformatf("q%0d_base", k), int'(out_base), qb[k]);
      beat(1'b1);
      check($sformatf("q%0d_done", k), int'(job_done), 1);
      exp_cnt++;
    end
    check("q_cnt", int'(jobs_done_count), exp_cnt);
    wait_idle(20);

    // Timeout after 16 silent RUN cycles; the following job proceeds and a mid-job beat restarts the stall timer.
    push('h70, 8, 2);
    push('h78, 8, 1);
    wait_start(10, n);
    check("to_base", int'(out_base), 'h70);
    n = 0;
    while (start_output && n < 40) begin
      tick();
      n++;
    end
    check("to_run_len", n, 16);
    check("to_done", int'(job_done), 1);
    check("to_status", int'(job_status), 1);
    check("to_err", int'(err_sticky), 1);
    exp_cnt++;
    check("to_cnt", int'(jobs_done_count), exp_cnt);
    wait_start(10, n);
    check("to_next_gap", n, 4);
    check("to_next_base", int'(out_base), 'h78);
    repeat (10) tick();
    beat(1'b0);
    repeat (10) tick();
    check("stall_reset", int'(start_output), 1);
    beat(1'b1);
    check("to_next_done", int'(job_done), 1);
    check("to_next_status", int'(job_status), 0);
    check("to_err_hold", int'(err_sticky), 1);
    exp_cnt++;
    wait_idle(20);

    // Reset in the middle of RUN with a second descriptor still queued.
    push('hA0, 8, 1);
    push('hA8, 8, 1);
    wait_start(10, n);
    repeat (3) tick();
    m_axis_aresetn = 1'b0;
    tick();
    check("mr_start", int'(start_output), 0);
    check("mr_done", int'(job_done), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_cnt", int'(jobs_done_count), 0);
    check("mr_err", int'(err_sticky), 0);
    m_axis_aresetn = 1'b1;
    tick();
    check("mr_rdy", int'(desc_ready), 1);
    check("mr_done_rel", int'(job_done), 0);
    repeat (4) tick();
    check("mr_flushed_start", int'(start_output), 0);
    check("mr_flushed_busy", int'(busy), 0);
    exp_cnt = 0;

    // tlast beat lands on the cycle the stall timer expires: completion wins.
    push('h90, 8, 1);
    wait_start(10, n);
    repeat (15) tick();
    check("co_pre_start", int'(start_output), 1);
    beat(1'b1);
    check("co_done", int'(job_done), 1);
    check("co_status", int'(job_status), 0);
    check("co_err", int'(err_sticky), 0);
    check("co_start", int'(start_output), 0);
    exp_cnt++;
    check("co_cnt", int'(jobs_done_count), exp_cnt);
    wait_idle(20);

    // Bad descriptors (size 0, then groups 0) never raise start_output; the valid one runs.
    push('hB0, 0, 2);
    push('hB8, 5, 0);
    push('hC0, 2, 1);
    n = 0;
    pulses = 0;
    bad_pulses = 0;
    while (!start_output && n < 40) begin
      if (job_done) begin
        pulses++;
        if (job_status == 2'd2) bad_pulses++;
      end
      tick();
      n++;
    end
    check("bd_pulses", pulses, 2);
    check("bd_status2", bad_pulses, 2);
    check("bd_start", int'(start_output), 1);
    check("bd_base", int'(out_base), 'hC0);
    check("bd_err", int'(err_sticky), 1);
    exp_cnt += 2;
    beat(1'b1);
    check("bd_ok_done", int'(job_done), 1);
    check("bd_ok_status", int'(job_status), 0);
    exp_cnt++;
    check("bd_cnt", int'(jobs_done_count), exp_cnt);
    wait_idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
